// File: rtl/axi_cfg_regfile.sv
// AXI4 responder exposing a bank of 64-bit configuration registers to the CGRA datapath.
// Independent write and read engines, one transaction each in flight; CTRL bit0 issues a start pulse.
module axi_cfg_regfile #(
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    DATA_WIDTH = 64,
  parameter int                    ID_WIDTH   = 5,
  parameter int                    NUM_REGS   = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 64'h5000_0000
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [ID_WIDTH-1:0]            aw_id_i,
  input  logic [ADDR_WIDTH-1:0]          aw_addr_i,
  input  logic [7:0]                     aw_len_i,
  input  logic [2:0]                     aw_size_i,
  input  logic [1:0]                     aw_burst_i,
  input  logic                           aw_valid_i,
  output logic                           aw_ready_o,
  input  logic [DATA_WIDTH-1:0]          w_data_i,
  input  logic [DATA_WIDTH/8-1:0]        w_strb_i,
  input  logic                           w_last_i,
  input  logic                           w_valid_i,
  output logic                           w_ready_o,
  output logic [ID_WIDTH-1:0]            b_id_o,
  output logic [1:0]                     b_resp_o,
  output logic                           b_valid_o,
  input  logic                           b_ready_i,
  input  logic [ID_WIDTH-1:0]            ar_id_i,
  input  logic [ADDR_WIDTH-1:0]          ar_addr_i,
  input  logic [7:0]                     ar_len_i,
  input  logic [2:0]                     ar_size_i,
  input  logic [1:0]                     ar_burst_i,
  input  logic                           ar_valid_i,
  output logic                           ar_ready_o,
  output logic [ID_WIDTH-1:0]            r_id_o,
  output logic [DATA_WIDTH-1:0]          r_data_o,
  output logic [1:0]                     r_resp_o,
  output logic                           r_last_o,
  output logic                           r_valid_o,
  input  logic                           r_ready_i,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  input  logic [DATA_WIDTH-1:0]          status_i,
  output logic                           start_o
);

  localparam int                    IDX_W        = $clog2(NUM_REGS);
  localparam int                    STRB_W       = DATA_WIDTH / 8;
  localparam logic [IDX_W-1:0]      CTRL_IDX     = IDX_W'(10);
  localparam logic [IDX_W-1:0]      STATUS_IDX   = IDX_W'(11);
  localparam logic [ADDR_WIDTH-1:0] REGION_BYTES = ADDR_WIDTH'(NUM_REGS * 8);
  localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES   = ADDR_WIDTH'(8);
  localparam logic [1:0]            BURST_FIXED  = 2'b00;
  localparam logic [1:0]            RESP_OKAY    = 2'b00;
  localparam logic [1:0]            RESP_SLVERR  = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wstate_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_e;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  wstate_e               wstate_q, wstate_d;
  logic [ID_WIDTH-1:0]   wid_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [1:0]            wburst_q;
  logic                  werr_q;
  logic [1:0]            bresp_q;
  logic                  start_q;

  rstate_e               rstate_q, rstate_d;
  logic [ID_WIDTH-1:0]   rid_q;
  logic [ADDR_WIDTH-1:0] raddr_q;
  logic [1:0]            rburst_q;
  logic [7:0]            rlen_q;
  logic [7:0]            rbeat_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic                  rlast_q;

  logic                  aw_hs_s, w_hs_s, ar_hs_s, r_hs_s;
  logic [ADDR_WIDTH-1:0] w_off_s, w_next_addr_s;
  logic                  w_ok_s, wr_en_s;
  logic [IDX_W-1:0]      w_idx_s;
  logic [DATA_WIDTH-1:0] wr_merged_s;
  logic [ADDR_WIDTH-1:0] r_next_addr_s, rd_src_addr_s, rd_off_s;
  logic                  rd_ok_s;
  logic [IDX_W-1:0]      rd_idx_s;
  logic [DATA_WIDTH-1:0] rd_val_s;
  logic                  unused_s;

  // Length and size are not needed: w_last terminates writes, beats are always 8 bytes.
  assign unused_s = ^{aw_len_i, aw_size_i, ar_size_i};

  assign aw_ready_o = (wstate_q == W_IDLE) && !rst_i;
  assign w_ready_o  = (wstate_q == W_DATA) && !rst_i;
  assign b_valid_o  = (wstate_q == W_RESP);
  assign b_id_o     = wid_q;
  assign b_resp_o   = bresp_q;
  assign start_o    = start_q;

  assign ar_ready_o = (rstate_q == R_IDLE) && !rst_i;
  assign r_valid_o  = (rstate_q == R_DATA);
  assign r_id_o     = rid_q;
  assign r_data_o   = rdata_q;
  assign r_resp_o   = rresp_q;
  assign r_last_o   = rlast_q && (rstate_q == R_DATA);

  assign aw_hs_s = aw_valid_i && aw_ready_o;
  assign w_hs_s  = w_valid_i && w_ready_o;
  assign ar_hs_s = ar_valid_i && ar_ready_o;
  assign r_hs_s  = r_valid_o && r_ready_i;

  assign w_off_s       = waddr_q - BASE_ADDR;
  assign w_ok_s        = (waddr_q >= BASE_ADDR) && (w_off_s < REGION_BYTES);
  assign w_idx_s       = w_off_s[3 +: IDX_W];
  assign w_next_addr_s = (wburst_q == BURST_FIXED) ? waddr_q : (waddr_q + BEAT_BYTES);
  assign wr_en_s       = w_hs_s && w_ok_s && (w_idx_s != STATUS_IDX);

  genvar gi;
  for (gi = 0; gi < NUM_REGS; gi++) begin : g_regs_out
    assign regs_o[gi*DATA_WIDTH +: DATA_WIDTH] = regs_q[gi];
  end

  // Byte-lane merge of the current write beat; CTRL bit0 is a trigger and never stored.
  always_comb begin
    wr_merged_s = regs_q[w_idx_s];
    for (int b = 0; b < STRB_W; b++) begin
      if (w_strb_i[b]) begin
        wr_merged_s[8*b +: 8] = w_data_i[8*b +: 8];
      end else begin
        wr_merged_s[8*b +: 8] = regs_q[w_idx_s][8*b +: 8];
      end
    end
    wr_merged_s[0] = wr_merged_s[0] && (w_idx_s != CTRL_IDX);
  end

  // Write engine next state.
  always_comb begin
    wstate_d = wstate_q;
    case (wstate_q)
      W_IDLE: begin
        if (aw_hs_s) wstate_d = W_DATA;
        else         wstate_d = W_IDLE;
      end
      W_DATA: begin
        if (w_hs_s && w_last_i) wstate_d = W_RESP;
        else                    wstate_d = W_DATA;
      end
      W_RESP: begin
        if (b_ready_i) wstate_d = W_IDLE;
        else           wstate_d = W_RESP;
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // Write engine state, latched AW fields, sticky error and start pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wstate_q <= W_IDLE;
      wid_q    <= '0;
      waddr_q  <= '0;
      wburst_q <= 2'b00;
      werr_q   <= 1'b0;
      bresp_q  <= RESP_OKAY;
      start_q  <= 1'b0;
    end else begin
      wstate_q <= wstate_d;
      start_q  <= w_hs_s && w_ok_s && (w_idx_s == CTRL_IDX) && w_strb_i[0] && w_data_i[0];
      if (aw_hs_s) begin
        wid_q    <= aw_id_i;
        waddr_q  <= aw_addr_i;
        wburst_q <= aw_burst_i;
        werr_q   <= 1'b0;
      end else if (w_hs_s) begin
        waddr_q <= w_next_addr_s;
        werr_q  <= werr_q || !w_ok_s;
        if (w_last_i) begin
          bresp_q <= (werr_q || !w_ok_s) ? RESP_SLVERR : RESP_OKAY;
        end
      end
    end
  end

  // Register bank storage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en_s) begin
      regs_q[w_idx_s] <= wr_merged_s;
    end
  end

  // The beat being launched comes from AR when idle, else from the advanced burst address.
  assign r_next_addr_s = (rburst_q == BURST_FIXED) ? raddr_q : (raddr_q + BEAT_BYTES);
  assign rd_src_addr_s = (rstate_q == R_IDLE) ? ar_addr_i : r_next_addr_s;
  assign rd_off_s      = rd_src_addr_s - BASE_ADDR;
  assign rd_ok_s       = (rd_src_addr_s >= BASE_ADDR) && (rd_off_s < REGION_BYTES);
  assign rd_idx_s      = rd_off_s[3 +: IDX_W];

  // Read data source for the launching beat.
  always_comb begin
    rd_val_s = '0;
    if (!rd_ok_s) begin
      rd_val_s = '0;
    end else if (rd_idx_s == STATUS_IDX) begin
      rd_val_s = status_i;
    end else begin
      rd_val_s = regs_q[rd_idx_s];
    end
  end

  // Read engine next state.
  always_comb begin
    rstate_d = rstate_q;
    case (rstate_q)
      R_IDLE: begin
        if (ar_hs_s) rstate_d = R_DATA;
        else         rstate_d = R_IDLE;
      end
      R_DATA: begin
        if (r_hs_s && rlast_q) rstate_d = R_IDLE;
        else                   rstate_d = R_DATA;
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // Read engine state and registered R payload, held while r_ready is low.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rstate_q <= R_IDLE;
      rid_q    <= '0;
      raddr_q  <= '0;
      rburst_q <= 2'b00;
      rlen_q   <= 8'd0;
      rbeat_q  <= 8'd0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
      rlast_q  <= 1'b0;
    end else begin
      rstate_q <= rstate_d;
      if (ar_hs_s) begin
        rid_q    <= ar_id_i;
        raddr_q  <= ar_addr_i;
        rburst_q <= ar_burst_i;
        rlen_q   <= ar_len_i;
        rbeat_q  <= 8'd0;
        rdata_q  <= rd_val_s;
        rresp_q  <= rd_ok_s ? RESP_OKAY : RESP_SLVERR;
        rlast_q  <= (ar_len_i == 8'd0);
      end else if (r_hs_s && !rlast_q) begin
        raddr_q <= rd_src_addr_s;
        rbeat_q <= rbeat_q + 8'd1;
        rdata_q <= rd_val_s;
        rresp_q <= rd_ok_s ? RESP_OKAY : RESP_SLVERR;
        rlast_q <= ((rbeat_q + 8'd1) == rlen_q);
      end
    end
  end

endmodule

// File: tb/tb_axi_cfg_regfile.sv
// Self-checking bench for axi_cfg_regfile: single-beat vector table plus burst,
// back-pressure and mid-transaction reset sequences, with B/R scoreboard queues.
module tb_axi_cfg_regfile;

  localparam logic [63:0] BASE = 64'h5000_0000;
  localparam logic [1:0]  INCR = 2'b01;
  localparam logic [1:0]  FIXD = 2'b00;
  localparam logic [1:0]  OKAY = 2'b00;
  localparam logic [1:0]  SLV  = 2'b10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [4:0]    aw_id, ar_id, b_id, r_id;
  logic [63:0]   aw_addr, ar_addr, w_data, r_data, status;
  logic [7:0]    aw_len, ar_len, w_strb;
  logic [2:0]    aw_size, ar_size;
  logic [1:0]    aw_burst, ar_burst, b_resp, r_resp;
  logic          aw_valid, aw_ready, w_last, w_valid, w_ready, b_valid, b_ready;
  logic          ar_valid, ar_ready, r_last, r_valid, r_ready, start;
  logic [1023:0] regs;

  always #5 clk = ~clk;

  axi_cfg_regfile dut (
    .clk_i(clk), .rst_i(rst),
    .aw_id_i(aw_id), .aw_addr_i(aw_addr), .aw_len_i(aw_len), .aw_size_i(aw_size),
    .aw_burst_i(aw_burst), .aw_valid_i(aw_valid), .aw_ready_o(aw_ready),
    .w_data_i(w_data), .w_strb_i(w_strb), .w_last_i(w_last), .w_valid_i(w_valid),
    .w_ready_o(w_ready),
    .b_id_o(b_id), .b_resp_o(b_resp), .b_valid_o(b_valid), .b_ready_i(b_ready),
    .ar_id_i(ar_id), .ar_addr_i(ar_addr), .ar_len_i(ar_len), .ar_size_i(ar_size),
    .ar_burst_i(ar_burst), .ar_valid_i(ar_valid), .ar_ready_o(ar_ready),
    .r_id_o(r_id), .r_data_o(r_data), .r_resp_o(r_resp), .r_last_o(r_last),
    .r_valid_o(r_valid), .r_ready_i(r_ready),
    .regs_o(regs), .status_i(status), .start_o(start)
  );

  typedef struct {
    logic [4:0] id;
    logic [1:0] resp;
  } b_exp_t;

  typedef struct {
    logic [4:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_exp_t;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [1:0]  bresp;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        start;
  } vec_t;

  int          tests = 0;
  int          fails = 0;
  b_exp_t      b_q[$];
  r_exp_t      r_q[$];
  b_exp_t      be;
  r_exp_t      re;
  logic [63:0] model [16];
  vec_t        vt [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_b(input logic [4:0] id, input logic [1:0] resp);
    b_exp_t e;
    e.id = id; e.resp = resp;
    b_q.push_back(e);
  endtask

  task automatic exp_r(input logic [4:0] id, input logic [63:0] data, input logic [1:0] resp,
                       input logic last);
    r_exp_t e;
    e.id = id; e.data = data; e.resp = resp; e.last = last;
    r_q.push_back(e);
  endtask

  task automatic model_write(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] strb);
    int idx;
    if (addr >= BASE && (addr - BASE) < 64'd128) begin
      idx = int'((addr - BASE) >> 3);
      if (idx != 11) begin
        for (int b = 0; b < 8; b++) begin
          if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
        end
        if (idx == 10) model[idx][0] = 1'b0;
      end
    end
  endtask

  task automatic check_regs(input string name);
    for (int i = 0; i < 16; i++) begin
      check(name, regs[64*i +: 64], model[i]);
    end
  endtask

  // Scoreboard: responses compared at the falling edge, where handshakes are settled.
  always @(negedge clk) begin
    if (!rst && b_valid && b_ready) begin
      tests++;
      if (b_q.size() == 0) begin
        fails++;
        $display("FAIL b_unexpected: got B id 0x%0h, expected no response", b_id);
      end else begin
        be = b_q.pop_front();
        if (b_id !== be.id || b_resp !== be.resp) begin
          fails++;
          $display("FAIL b_beat: got id 0x%0h resp %0d, expected id 0x%0h resp %0d",
                   b_id, b_resp, be.id, be.resp);
        end
      end
    end
    if (!rst && r_valid) begin
      tests++;
      if (r_q.size() == 0) begin
        fails++;
        $display("FAIL r_unexpected: got R data 0x%0h, expected no response", r_data);
      end else if (r_ready) begin
        re = r_q.pop_front();
        if (r_id !== re.id || r_data !== re.data || r_resp !== re.resp || r_last !== re.last) begin
          fails++;
          $display("FAIL r_beat: got id 0x%0h data 0x%0h resp %0d last %0d, expected id 0x%0h data 0x%0h resp %0d last %0d",
                   r_id, r_data, r_resp, r_last, re.id, re.data, re.resp, re.last);
        end
      end else if (r_data !== r_q[0].data || r_last !== r_q[0].last) begin
        fails++;
        $display("FAIL r_stall: got data 0x%0h last %0d, expected 0x%0h last %0d",
                 r_data, r_last, r_q[0].data, r_q[0].last);
      end
    end
  end

  task automatic do_aw(input logic [4:0] id, input logic [63:0] addr, input logic [7:0] len,
                       input logic [1:0] burst);
    int n = 0;
    aw_id = id; aw_addr = addr; aw_len = len; aw_size = 3'd3; aw_burst = burst; aw_valid = 1'b1;
    @(negedge clk);
    while (!aw_ready && n < 50) begin n++; @(negedge clk); end
    check("aw_accept", {63'd0, aw_ready}, 64'd1);
    @(posedge clk); #1;
    aw_valid = 1'b0;
  endtask

  task automatic do_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
    int n = 0;
    w_data = data; w_strb = strb; w_last = last; w_valid = 1'b1;
    @(negedge clk);
    while (!w_ready && n < 50) begin n++; @(negedge clk); end
    check("w_accept", {63'd0, w_ready}, 64'd1);
    @(posedge clk); #1;
    w_valid = 1'b0;
  endtask

  task automatic do_ar(input logic [4:0] id, input logic [63:0] addr, input logic [7:0] len,
                       input logic [1:0] burst);
    int n = 0;
    ar_id = id; ar_addr = addr; ar_len = len; ar_size = 3'd3; ar_burst = burst; ar_valid = 1'b1;
    @(negedge clk);
    while (!ar_ready && n < 50) begin n++; @(negedge clk); end
    check("ar_accept", {63'd0, ar_ready}, 64'd1);
    @(posedge clk); #1;
    ar_valid = 1'b0;
  endtask

  task automatic wait_b_done();
    int n = 0;
    while (b_q.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
    check("b_pending", 64'(b_q.size()), 64'd0);
    b_q.delete();
  endtask

  task automatic wait_r_done(input bit toggle);
    int n = 0;
    while (r_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      if (toggle) r_ready = !r_ready;
      n++;
    end
    r_ready = 1'b1;
    check("r_pending", 64'(r_q.size()), 64'd0);
    r_q.delete();
  endtask

  task automatic do_wburst(input logic [4:0] id, input logic [63:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [63:0] base, input logic [63:0] step,
                           input logic [1:0] resp);
    logic [63:0] a;
    a = addr;
    exp_b(id, resp);
    do_aw(id, addr, len, burst);
    for (int k = 0; k <= int'(len); k++) begin
      do_w(base + 64'(k) * step, 8'hFF, (k == int'(len)));
      model_write(a, base + 64'(k) * step, 8'hFF);
      if (burst != FIXD) a = a + 64'd8;
    end
    wait_b_done();
  endtask

  initial begin
    vt[0]  = '{64'h5000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, OKAY, 64'hFFFF_FFFF_FFFF_FFFF, OKAY, 1'b0};
    vt[1]  = '{64'h5000_0000, 64'h1122_3344_5566_7788, 8'h0F, OKAY, 64'hFFFF_FFFF_5566_7788, OKAY, 1'b0};
    vt[2]  = '{64'h5000_0050, 64'h0000_0000_0000_0001, 8'hFF, OKAY, 64'h0,                   OKAY, 1'b1};
    vt[3]  = '{64'h5000_0050, 64'h0000_0000_0000_F0F1, 8'hFF, OKAY, 64'h0000_0000_0000_F0F0, OKAY, 1'b1};
    vt[4]  = '{64'h5000_0050, 64'h0000_0000_0000_0003, 8'hFE, OKAY, 64'h0000_0000_0000_00F0, OKAY, 1'b0};
    vt[5]  = '{64'h5000_0080, 64'h0000_0000_0000_0055, 8'hFF, SLV,  64'h0,                   SLV,  1'b0};
    vt[6]  = '{64'h4FFF_FFF8, 64'h0000_0000_0000_0066, 8'hFF, SLV,  64'h0,                   SLV,  1'b0};
    vt[7]  = '{64'h5000_0058, 64'h0000_0000_0000_1234, 8'hFF, OKAY, 64'h0000_0000_DEAD_BEEF, OKAY, 1'b0};
    vt[8]  = '{64'h5000_0078, 64'h0000_0000_0000_CAFE, 8'h01, OKAY, 64'h0000_0000_0000_00FE, OKAY, 1'b0};
    vt[9]  = '{64'h5000_0007, 64'h1200_0000_0000_0000, 8'h80, OKAY, 64'h12FF_FFFF_5566_7788, OKAY, 1'b0};
    vt[10] = '{64'h5000_0048, 64'h0123_4567_89AB_CDEF, 8'hFF, OKAY, 64'h0123_4567_89AB_CDEF, OKAY, 1'b0};
    vt[11] = '{64'h5000_0060, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, OKAY, 64'h0,                   OKAY, 1'b0};

    for (int i = 0; i < 16; i++) model[i] = 64'd0;
    aw_id = 5'd0; aw_addr = 64'd0; aw_len = 8'd0; aw_size = 3'd3; aw_burst = INCR; aw_valid = 1'b0;
    ar_id = 5'd0; ar_addr = 64'd0; ar_len = 8'd0; ar_size = 3'd3; ar_burst = INCR; ar_valid = 1'b0;
    w_data = 64'd0; w_strb = 8'h00; w_last = 1'b0; w_valid = 1'b0;
    b_ready = 1'b1; r_ready = 1'b1; status = 64'h0000_0000_DEAD_BEEF;
    rst = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_aw_ready", {63'd0, aw_ready}, 64'd0);
    check("rst_ar_ready", {63'd0, ar_ready}, 64'd0);
    check("rst_w_ready",  {63'd0, w_ready},  64'd0);
    check("rst_b_valid",  {63'd0, b_valid},  64'd0);
    check("rst_r_valid",  {63'd0, r_valid},  64'd0);
    check("rst_r_last",   {63'd0, r_last},   64'd0);
    check("rst_start",    {63'd0, start},    64'd0);
    check("rst_r_data",   r_data,            64'd0);
    check_regs("rst_regs");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_aw_ready", {63'd0, aw_ready}, 64'd1);
    check("post_rst_ar_ready", {63'd0, ar_ready}, 64'd1);
    @(posedge clk); #1;

    // Single-beat write then readback for each vector.
    for (int i = 0; i < 12; i++) begin
      exp_b(5'(i), vt[i].bresp);
      do_aw(5'(i), vt[i].addr, 8'd0, INCR);
      do_w(vt[i].data, vt[i].strb, 1'b1);
      model_write(vt[i].addr, vt[i].data, vt[i].strb);
      @(negedge clk);
      check("start_pulse", {63'd0, start}, {63'd0, vt[i].start});
      check_regs("vec_regs");
      @(negedge clk);
      check("start_drop", {63'd0, start}, 64'd0);
      @(posedge clk); #1;
      wait_b_done();
      exp_r(5'(i + 16), vt[i].rdata, vt[i].rresp, 1'b1);
      do_ar(5'(i + 16), vt[i].addr, 8'd0, INCR);
      wait_r_done(1'b0);
    end

    // INCR burst write/read with r_ready toggling.
    do_wburst(5'd20, 64'h5000_0020, 8'd3, INCR, 64'hA0, 64'd1, OKAY);
    check_regs("incr_regs");
    exp_r(5'd21, 64'hA0, OKAY, 1'b0);
    exp_r(5'd21, 64'hA1, OKAY, 1'b0);
    exp_r(5'd21, 64'hA2, OKAY, 1'b0);
    exp_r(5'd21, 64'hA3, OKAY, 1'b1);
    do_ar(5'd21, 64'h5000_0020, 8'd3, INCR);
    wait_r_done(1'b1);

    // FIXED burst: both beats hit the same register.
    do_wburst(5'd22, 64'h5000_0030, 8'd1, FIXD, 64'h11, 64'h11, OKAY);
    check_regs("fixed_regs");
    exp_r(5'd23, 64'h22, OKAY, 1'b0);
    exp_r(5'd23, 64'h22, OKAY, 1'b1);
    do_ar(5'd23, 64'h5000_0030, 8'd1, FIXD);
    wait_r_done(1'b0);

    // INCR burst running off the top of the region.
    do_wburst(5'd24, 64'h5000_0078, 8'd1, INCR, 64'h77, 64'd1, SLV);
    check_regs("cross_regs");
    exp_r(5'd25, 64'h77, OKAY, 1'b0);
    exp_r(5'd25, 64'h0,  SLV,  1'b1);
    do_ar(5'd25, 64'h5000_0078, 8'd1, INCR);
    wait_r_done(1'b0);

    // B back-pressure while a read completes concurrently.
    b_ready = 1'b0;
    exp_b(5'd7, OKAY);
    do_aw(5'd7, 64'h5000_0008, 8'd0, INCR);
    do_w(64'h0000_0000_0BAD_F00D, 8'hFF, 1'b1);
    model_write(64'h5000_0008, 64'h0000_0000_0BAD_F00D, 8'hFF);
    exp_r(5'd8, 64'h0123_4567_89AB_CDEF, OKAY, 1'b1);
    do_ar(5'd8, 64'h5000_0048, 8'd0, INCR);
    wait_r_done(1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_b_valid",  {63'd0, b_valid},  64'd1);
      check("stall_aw_ready", {63'd0, aw_ready}, 64'd0);
      check("stall_b_id",     {59'd0, b_id},     64'd7);
      @(posedge clk); #1;
    end
    b_ready = 1'b1;
    wait_b_done();
    check_regs("stall_regs");

    // Reset during the data phase of a 4-beat burst.
    do_aw(5'd9, 64'h5000_0040, 8'd3, INCR);
    do_w(64'hB0, 8'hFF, 1'b0);
    model_write(64'h5000_0040, 64'hB0, 8'hFF);
    do_w(64'hB1, 8'hFF, 1'b0);
    model_write(64'h5000_0048, 64'hB1, 8'hFF);
    @(negedge clk);
    check_regs("partial_regs");
    @(posedge clk); #1;
    w_data = 64'hB2; w_last = 1'b0; w_valid = 1'b1;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) model[i] = 64'd0;
    check("mid_rst_w_ready",  {63'd0, w_ready},  64'd0);
    check("mid_rst_aw_ready", {63'd0, aw_ready}, 64'd0);
    check("mid_rst_b_valid",  {63'd0, b_valid},  64'd0);
    check("mid_rst_r_valid",  {63'd0, r_valid},  64'd0);
    check("mid_rst_start",    {63'd0, start},    64'd0);
    check_regs("mid_rst_regs");
    w_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rel_aw_ready", {63'd0, aw_ready}, 64'd1);
    check("rel_ar_ready", {63'd0, ar_ready}, 64'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rel_no_b", {63'd0, b_valid}, 64'd0);
    end
    @(posedge clk); #1;

    // Normal traffic after reset.
    exp_b(5'd3, OKAY);
    do_aw(5'd3, 64'h5000_0010, 8'd0, INCR);
    do_w(64'h0000_0000_0000_55AA, 8'hFF, 1'b1);
    model_write(64'h5000_0010, 64'h0000_0000_0000_55AA, 8'hFF);
    wait_b_done();
    check_regs("after_rst_regs");
    exp_r(5'd4, 64'h0000_0000_0000_55AA, OKAY, 1'b1);
    do_ar(5'd4, 64'h5000_0010, 8'd0, INCR);
    wait_r_done(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axi_cfg_regfile.md
# axi_cfg_regfile

AXI4 responder that terminates one crossbar master port and exposes a bank of 64-bit configuration registers to the accelerator (CGRA) datapath. It accepts single-beat and INCR/FIXED burst writes and reads, returns B/R responses with the request ID, and issues a one-cycle start pulse when software sets the CTRL start bit. One write and one read transaction are in flight at a time, processed independently.

## Interface
- ADDR_WIDTH, 64, AXI address width
- DATA_WIDTH, 64, AXI data width (fixed 64; 8-byte registers)
- ID_WIDTH, 5, AXI ID width (crossbar master-side ID width)
- NUM_REGS, 16, register count (power of 2, ≥12)
- BASE_ADDR, 64'h5000_0000, region base; offset = addr − BASE_ADDR
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- aw_id/aw_addr/aw_len/aw_size/aw_burst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  write address channel
- aw_valid  in  1; aw_ready  out  1
- w_data/w_strb/w_last  in  64/8/1  write data channel
- w_valid  in  1; w_ready  out  1
- b_id/b_resp  out  ID_WIDTH/2; b_valid  out  1; b_ready  in  1
- ar_id/ar_addr/ar_len/ar_size/ar_burst  in  as AW; ar_valid  in  1; ar_ready  out  1
- r_id/r_data/r_resp/r_last  out  ID_WIDTH/64/2/1; r_valid  out  1; r_ready  in  1
- regs_o  out  NUM_REGS*64  current register contents, reg i at bits [64i+63:64i]
- status_i  in  64  read-only status, visible at index 11
- start_o  out  1  one-cycle start pulse

## Operation
- Index = offset[3 +: log2(NUM_REGS)]; offset[2:0] ignored. Offset ≥ NUM_REGS*8 (or addr < BASE_ADDR) is out of range.
- Index 10 (offset 0x50) CTRL: bit0 write-1 → start_o; bit0 not stored (reads 0); bits 63:1 stored.
- Index 11 (offset 0x58) STATUS: reads status_i; writes discarded, response OKAY.
- Other indices: plain R/W, byte-lane write per w_strb (strobes honoured for any aw_size).
- Burst: INCR adds 8 to beat address each beat; FIXED holds it; WRAP treated as INCR. Beats = len+1.
- Write FSM: W_IDLE (aw_ready=1) -AW hs: latch id/addr/burst→ W_DATA (w_ready=1; each W hs writes one beat, advances address) -W hs with w_last→ W_RESP (b_valid=1) -b_ready→ W_IDLE. w_last is authoritative; aw_len is not checked against it.
- b_resp = SLVERR (2'b10) if any beat of the burst was out of range, else OKAY; out-of-range beats write nothing.
- Read FSM: R_IDLE (ar_ready=1) -AR hs: latch id/addr/len/burst→ R_DATA (r_valid=1, r_data held stable while r_ready=0) -R hs on final beat→ R_IDLE; otherwise next beat.
- r_resp per beat: SLVERR with r_data=0 when out of range, else OKAY. r_last=1 only on beat len+1.
- r_id = latched ar_id; b_id = latched aw_id.

## Timing
- Reset (rst_i high, async): all registers 0, FSMs idle, aw_ready=ar_ready=w_ready=b_valid=r_valid=r_last=start_o=0, b_resp=r_resp=0, r_data=0. Ready outputs are gated by rst_i; aw_ready/ar_ready rise the first cycle after deassertion.
- Reset mid-transaction: transaction dropped, no B/R issued, partially written beats remain until register reset clears them (all cleared).
- Write beat visible on regs_o the cycle after its W handshake.
- start_o high exactly the cycle after the W handshake with strb[0]=1 and data[0]=1 to CTRL; one pulse per such beat.
- b_valid asserts the cycle after the W handshake carrying w_last; earliest AW→B: 3 cycles for single beat (AW hs, W hs, B).
- r_valid asserts the cycle after the AR handshake; next beat's r_valid follows the cycle after each R hs (one bubble per beat max). r_data sampled from register state at the launching clock edge; a same-cycle write is not seen.
- Same-cycle read and write to the same index: read returns pre-write value.
- b_valid/r_valid never deassert before handshake; payload stable while stalled.

## Test plan
- AW addr 0x5000_0050, size 3, W data 0x1, strb 0xFF, last=1 → start_o one pulse cycle after W hs, b_resp OKAY, b_id=aw_id; read 0x5000_0050 → r_data 0x0, r_last=1.
- Write 0x5000_0000 data 0x1122_3344_5566_7788 strb 0x0F after writing all-ones → readback 0xFFFF_FFFF_5566_7788.
- INCR write len 3 at 0x5000_0020 data 0xA0..0xA3, then INCR read len 3 → r_data 0xA0,0xA1,0xA2,0xA3, r_last only on 4th; r_ready toggled 1/0 holds data stable.
- Write 0x5000_0080 (NUM_REGS=16) → b_resp SLVERR, regs_o unchanged; read it → r_resp SLVERR, r_data 0.
- b_ready low 5 cycles after write → b_valid held, no new AW accepted (aw_ready=0) until B hs; concurrent read completes meanwhile.
- status_i=0xDEAD_BEEF, read 0x5000_0058 → 0xDEAD_BEEF; assert rst_i during W_DATA of len-3 burst → all outputs to reset values immediately, regs_o=0, no B response.
